// File: rtl/iterative_shifter.sv
// -----------------------------------------------------------------------------
// iterative_shifter
//
// Multi-cycle shifter with a valid/ready request channel and a valid/ready
// result channel. It shifts the operand by at most STEP bits per clock, so a
// shift of A bits takes ceil(A/STEP) clocks in the shift state. A request is
// taken in IDLE. The unit then shifts in SHIFT and holds the result in DONE
// until the consumer takes it.
//
// Optional feature (compile-time macro ITERATIVE_SHIFTER_ROTATE_EN):
//   Adds the 'rotate' input. When rotate is 1 the unit rotates instead of
//   shifting, using an amount of shift_amount mod WIDTH.
//
// Ports:
//   clk           in   clock, rising edge
//   reset_n       in   asynchronous active-low reset
//   req_valid     in   request present
//   req_ready     out  unit can accept a request (IDLE)
//   value         in   operand to shift
//   shift_amount  in   unsigned shift distance, 0..2*WIDTH-1
//   direction     in   0 = left, 1 = right
//   arithmetic    in   1 = sign-fill on right shift (ignored on left shift)
//   rotate        in   1 = rotate, overrides arithmetic (macro builds only)
//   result_valid  out  result available (DONE)
//   result_ready  in   consumer takes the result
//   result        out  shifted value (registered)
//   busy          out  high whenever the unit is not in IDLE
// -----------------------------------------------------------------------------
module iterative_shifter #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned STEP  = 4
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic [WIDTH-1:0]           value,
   input  logic [$clog2(WIDTH):0]     shift_amount,
   input  logic                       direction,
   input  logic                       arithmetic,
`ifdef ITERATIVE_SHIFTER_ROTATE_EN
   input  logic                       rotate,
`endif
   output logic                       result_valid,
   input  logic                       result_ready,
   output logic [WIDTH-1:0]           result,
   output logic                       busy
);

   localparam int unsigned AW = $clog2(WIDTH) + 1;
   localparam logic [AW-1:0] WidthAmt = AW'(WIDTH);
   localparam logic [AW-1:0] StepAmt  = AW'(STEP);

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  data_q, data_d;
   logic [WIDTH-1:0]  result_q, result_d;
   logic [AW-1:0]     rem_q, rem_d;
   logic              dir_q, dir_d;
   logic              arith_q, arith_d;
   logic              rot_q, rot_d;

   logic              rot_in;
   logic [AW-1:0]     amt_eff;
   logic [AW-1:0]     step;
   logic [WIDTH-1:0]  shifted;
   logic [2*WIDTH-1:0] dbl;

`ifdef ITERATIVE_SHIFTER_ROTATE_EN
   assign rot_in = rotate;
`else
   assign rot_in = 1'b0;
`endif

   // Effective amount: rotates wrap modulo WIDTH, shifts saturate at WIDTH
   // (shifting WIDTH bits already gives all-fill, so larger amounts are equal).
   always_comb begin
      amt_eff = shift_amount;
      if (rot_in) begin
         amt_eff = {1'b0, shift_amount[AW-2:0]};
      end else if (shift_amount > WidthAmt) begin
         amt_eff = WidthAmt;
      end
   end

   assign step = (rem_q < StepAmt) ? rem_q : StepAmt;

   // One shift of the working register by 'step' bits.
   always_comb begin
      dbl     = {data_q, data_q};
      shifted = data_q;
      if (rot_q) begin
         if (dir_q) begin
            dbl     = dbl >> step;
            shifted = dbl[WIDTH-1:0];
         end else begin
            dbl     = dbl << step;
            shifted = dbl[2*WIDTH-1:WIDTH];
         end
      end else if (dir_q) begin
         if (arith_q) begin
            shifted = $signed(data_q) >>> step;
         end else begin
            shifted = data_q >> step;
         end
      end else begin
         shifted = data_q << step;
      end
   end

   always_comb begin
      state_d  = state_q;
      data_d   = data_q;
      result_d = result_q;
      rem_d    = rem_q;
      dir_d    = dir_q;
      arith_d  = arith_q;
      rot_d    = rot_q;
      unique case (state_q)
         StIdle: begin
            if (req_valid) begin
               data_d  = value;
               dir_d   = direction;
               arith_d = arithmetic;
               rot_d   = rot_in;
               rem_d   = amt_eff;
               if (amt_eff == '0) begin
                  result_d = value;
                  state_d  = StDone;
               end else begin
                  state_d  = StShift;
               end
            end
         end
         StShift: begin
            data_d = shifted;
            rem_d  = rem_q - step;
            if (rem_q <= StepAmt) begin
               result_d = shifted;
               state_d  = StDone;
            end
         end
         StDone: begin
            if (result_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= StIdle;
         data_q   <= '0;
         result_q <= '0;
         rem_q    <= '0;
         dir_q    <= 1'b0;
         arith_q  <= 1'b0;
         rot_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         data_q   <= data_d;
         result_q <= result_d;
         rem_q    <= rem_d;
         dir_q    <= dir_d;
         arith_q  <= arith_d;
         rot_q    <= rot_d;
      end
   end

   assign req_ready    = (state_q == StIdle);
   assign busy         = (state_q != StIdle);
   assign result_valid = (state_q == StDone);
   assign result       = result_q;

endmodule

// File: tb/tb_iterative_shifter.sv
// -----------------------------------------------------------------------------
// tb_iterative_shifter
//
// Directed testbench for iterative_shifter (WIDTH=32, STEP=4). The expected
// results and latencies are computed by hand. Latency is the index of the
// first clock edge after the accept edge at which result_valid is sampled
// high. Inputs are driven and outputs sampled on the falling edge.
// Rotate vectors run only when ITERATIVE_SHIFTER_ROTATE_EN is defined.
// -----------------------------------------------------------------------------
module tb_iterative_shifter;

   logic        clk;
   logic        reset_n;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] value;
   logic [5:0]  shift_amount;
   logic        direction;
   logic        arithmetic;
   logic        rotate;
   logic        result_valid;
   logic        result_ready;
   logic [31:0] result;
   logic        busy;

   int n_vec  = 0;
   int n_miss = 0;

   iterative_shifter #(
      .WIDTH (32),
      .STEP  (4)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .value        (value),
      .shift_amount (shift_amount),
      .direction    (direction),
      .arithmetic   (arithmetic),
`ifdef ITERATIVE_SHIFTER_ROTATE_EN
      .rotate       (rotate),
`endif
      .result_valid (result_valid),
      .result_ready (result_ready),
      .result       (result),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // One request with result_ready held high; checks result, latency and the
   // single-cycle result_valid pulse. Inputs are scrambled after the accept
   // edge so that only the registered copies can produce the right answer.
   task automatic run_op(input string tag, input logic [31:0] v, input logic [5:0] amt,
                         input logic dir, input logic ar, input logic rot,
                         input logic [31:0] exp, input int exp_lat);
      int lat;
      @(negedge clk);
      check({tag, ".req_ready"}, req_ready, 1);
      req_valid    = 1'b1;
      value        = v;
      shift_amount = amt;
      direction    = dir;
      arithmetic   = ar;
      rotate       = rot;
      result_ready = 1'b1;
      @(negedge clk);
      req_valid    = 1'b0;
      value        = ~v;
      direction    = ~dir;
      arithmetic   = ~ar;
      rotate       = ~rot;
      shift_amount = amt + 6'd3;
      lat = 1;
      while (!result_valid && lat < 64) begin
         @(negedge clk);
         lat++;
      end
      check({tag, ".latency"}, lat, exp_lat);
      check({tag, ".result"}, result, exp);
      @(negedge clk);
      check({tag, ".valid_drop"}, {result_valid, busy, req_ready}, 3'b001);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset_n      = 1'b0;
      req_valid    = 1'b0;
      value        = '0;
      shift_amount = '0;
      direction    = 1'b0;
      arithmetic   = 1'b0;
      rotate       = 1'b0;
      result_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("reset.outputs", {req_ready, result_valid, busy}, 3'b100);
      check("reset.result", result, 32'h0);
      reset_n = 1'b1;

      run_op("left10",    32'hFFFF_FFFF, 6'd10, 1'b0, 1'b0, 1'b0, 32'hFFFF_FC00, 4);
      run_op("lsr10",     32'hFFFF_FFFF, 6'd10, 1'b1, 1'b0, 1'b0, 32'h003F_FFFF, 4);
      run_op("asr4",      32'h8000_0000, 6'd4,  1'b1, 1'b1, 1'b0, 32'hF800_0000, 2);
      run_op("amt0",      32'h1234_5678, 6'd0,  1'b0, 1'b0, 1'b0, 32'h1234_5678, 1);
      run_op("left32",    32'hFFFF_FFFF, 6'd32, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 9);
      run_op("left40",    32'hFFFF_FFFF, 6'd40, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 9);
      run_op("asr40",     32'h8000_0000, 6'd40, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 9);
      run_op("asr40pos",  32'h4000_0000, 6'd40, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 9);
      run_op("lsr63",     32'h8000_0000, 6'd63, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 9);
      run_op("left_arith",32'h8000_0001, 6'd1,  1'b0, 1'b1, 1'b0, 32'h0000_0002, 2);
      run_op("asr7pos",   32'h1234_5678, 6'd7,  1'b1, 1'b1, 1'b0, 32'h0024_68AC, 3);
      run_op("left7",     32'h1234_5678, 6'd7,  1'b0, 1'b0, 1'b0, 32'h1A2B_3C00, 3);

      // Backpressure: result must hold while result_ready is low.
      begin
         int lat;
         @(negedge clk);
         req_valid    = 1'b1;
         value        = 32'h0000_00FF;
         shift_amount = 6'd8;
         direction    = 1'b0;
         arithmetic   = 1'b0;
         rotate       = 1'b0;
         result_ready = 1'b0;
         @(negedge clk);
         req_valid = 1'b0;
         value     = 32'hDEAD_BEEF;
         lat = 1;
         while (!result_valid && lat < 64) begin
            @(negedge clk);
            lat++;
         end
         check("bp.latency", lat, 3);
         for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp.hold_flags", {result_valid, busy, req_ready}, 3'b110);
            check("bp.hold_result", result, 32'h0000_FF00);
         end
         result_ready = 1'b1;
         @(negedge clk);
         check("bp.release", {result_valid, busy, req_ready}, 3'b001);
         // Back-to-back request taken on the very next edge.
         req_valid    = 1'b1;
         value        = 32'hA5A5_A5A5;
         shift_amount = 6'd0;
         @(negedge clk);
         req_valid = 1'b0;
         check("b2b.accepted", {result_valid, busy, req_ready}, 3'b110);
         check("b2b.result", result, 32'hA5A5_A5A5);
      end

      // Reset in the second SHIFT cycle of an amt=20 operation.
      @(negedge clk);
      req_valid    = 1'b1;
      value        = 32'h0000_0001;
      shift_amount = 6'd20;
      direction    = 1'b0;
      arithmetic   = 1'b0;
      rotate       = 1'b0;
      result_ready = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      check("rst.mid_busy", busy, 1);
      reset_n = 1'b0;
      #1;
      check("rst.mid_flags", {req_ready, result_valid, busy}, 3'b100);
      check("rst.mid_result", result, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (7) @(negedge clk);
      check("rst.no_result", {result_valid, busy}, 2'b00);
      run_op("post_rst", 32'h0000_0001, 6'd1, 1'b0, 1'b0, 1'b0, 32'h0000_0002, 2);

`ifdef ITERATIVE_SHIFTER_ROTATE_EN
      run_op("rotl4",  32'h8000_0001, 6'd4,  1'b0, 1'b0, 1'b1, 32'h0000_0018, 2);
      run_op("rotr36", 32'h8000_0001, 6'd36, 1'b1, 1'b1, 1'b1, 32'h1800_0000, 2);
      run_op("rotl32", 32'h1234_5678, 6'd32, 1'b0, 1'b0, 1'b1, 32'h1234_5678, 1);
      run_op("rotr9",  32'h0000_01FF, 6'd9,  1'b1, 1'b0, 1'b1, 32'hFF80_0000, 4);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
